// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 11-bit alu between two requesters.
// Round-robin grant with a bounded lock, a registered operand stage feeding
// the alu, and a registered result stage steered back to the requesting port.
//
// Handshake: a request is accepted on a rising edge where reqN_valid and
// reqN_ready are both high; reqN_ready is combinational from registered
// state and the two valids only, and is low while reset is high. Responses
// are single-cycle rspN_valid pulses with no ready; the pipeline never stalls.

`ifndef ADDMODULE
`define ADDMODULE 4'd0
`endif
`ifndef SUBMODULE
`define SUBMODULE 4'd1
`endif
`ifndef MULMODULE
`define MULMODULE 4'd2
`endif
`ifndef NOTMODULE
`define NOTMODULE 4'd3
`endif

// alu: 11-bit two's-complement add/sub/mul/not with signed compare flags.
module alu (
  input  logic [10:0] in0,
  input  logic [10:0] in1,
  input  logic [3:0]  funct,
  output logic [10:0] out,
  output logic        overflow,
  output logic        gr,
  output logic        le,
  output logic        eq
);

  logic [11:0] sum;
  logic [11:0] diff;
  logic [21:0] in0_x;
  logic [21:0] in1_x;
  logic [21:0] prod;

  // One extra bit on add/sub exposes signed overflow as a sign disagreement.
  assign sum   = {in0[10], in0} + {in1[10], in1};
  assign diff  = {in0[10], in0} - {in1[10], in1};
  // Sign-extended operands give the exact low 22 bits of the signed product.
  assign in0_x = {{11{in0[10]}}, in0};
  assign in1_x = {{11{in1[10]}}, in1};
  assign prod  = in0_x * in1_x;

  // Select the result and overflow for the requested function.
  always_comb begin
    out      = 11'd0;
    overflow = 1'b0;
    case (funct)
      `ADDMODULE: begin
        out      = sum[10:0];
        overflow = sum[11] ^ sum[10];
      end
      `SUBMODULE: begin
        out      = diff[10:0];
        overflow = diff[11] ^ diff[10];
      end
      `MULMODULE: begin
        out      = prod[10:0];
        overflow = (prod[21:10] != {12{prod[10]}});
      end
      `NOTMODULE: begin
        out      = ~in0;
        overflow = 1'b0;
      end
      default: begin
        out      = 11'd0;
        overflow = 1'b0;
      end
    endcase
  end

  // Signed comparison of the two operands, independent of funct.
  always_comb begin
    gr = ($signed(in0) >  $signed(in1));
    le = ($signed(in0) <  $signed(in1));
    eq = (in0 == in1);
  end

endmodule

module alu_arbiter #(
  parameter int MAX_LOCK  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_lock,
  input  logic [10:0]          req0_a,
  input  logic [10:0]          req0_b,
  input  logic [3:0]           req0_funct,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_lock,
  input  logic [10:0]          req1_a,
  input  logic [10:0]          req1_b,
  input  logic [3:0]           req1_funct,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [10:0]          rsp_data,
  output logic                 rsp_overflow,
  output logic                 rsp_gr,
  output logic                 rsp_le,
  output logic                 rsp_eq,
  output logic [CNT_WIDTH-1:0] ops0_count,
  output logic [CNT_WIDTH-1:0] ops1_count
);

  // Highest lock_cnt value from which a locked accept may still keep priority.
  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Arbitration state: prio = favoured port, lock_cnt = consecutive locked grants.
  logic       prio;
  logic [3:0] lock_cnt;

  logic acc0;
  logic acc1;
  logic acc_any;
  logic acc_port;
  logic acc_lock;

  // Stage 1: operands presented to the alu.
  logic        s1_valid;
  logic        s1_tag;
  logic [10:0] s1_a;
  logic [10:0] s1_b;
  logic [3:0]  s1_funct;

  // Stage 2: registered result ownership.
  logic s2_valid;
  logic s2_tag;

  logic [10:0] alu_out;
  logic        alu_overflow;
  logic        alu_gr;
  logic        alu_le;
  logic        alu_eq;

  // Grant: a lone requester wins; on contention prio decides; nothing during reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      req0_ready = req0_valid && (!req1_valid || !prio);
      req1_ready = req1_valid && (!req0_valid ||  prio);
    end
  end

  // Decode which port (if any) is accepted this cycle and whether it asked to lock.
  always_comb begin
    acc0     = req0_valid && req0_ready;
    acc1     = req1_valid && req1_ready;
    acc_any  = acc0 || acc1;
    acc_port = acc1;
    acc_lock = acc1 ? req1_lock : req0_lock;
  end

  // Priority pointer and lock counter: a locked accept keeps priority until the
  // counter reaches its limit, otherwise priority passes to the other port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio     <= 1'b0;
      lock_cnt <= 4'd0;
    end else if (acc_any) begin
      if (acc_lock && (lock_cnt < LOCK_LIMIT)) begin
        prio     <= acc_port;
        lock_cnt <= lock_cnt + 4'd1;
      end else begin
        prio     <= ~acc_port;
        lock_cnt <= 4'd0;
      end
    end else begin
      lock_cnt <= 4'd0;
    end
  end

  // Stage 1: capture the accepted operation's operands and originating port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_a     <= 11'd0;
      s1_b     <= 11'd0;
      s1_funct <= 4'd0;
    end else begin
      s1_valid <= acc_any;
      if (acc_any) begin
        s1_tag   <= acc_port;
        s1_a     <= acc_port ? req1_a     : req0_a;
        s1_b     <= acc_port ? req1_b     : req0_b;
        s1_funct <= acc_port ? req1_funct : req0_funct;
      end
    end
  end

  alu u_alu (
    .in0      (s1_a),
    .in1      (s1_b),
    .funct    (s1_funct),
    .out      (alu_out),
    .overflow (alu_overflow),
    .gr       (alu_gr),
    .le       (alu_le),
    .eq       (alu_eq)
  );

  // Stage 2: register the alu result; data and flags hold when no op retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid     <= 1'b0;
      s2_tag       <= 1'b0;
      rsp_data     <= 11'd0;
      rsp_overflow <= 1'b0;
      rsp_gr       <= 1'b0;
      rsp_le       <= 1'b0;
      rsp_eq       <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag       <= s1_tag;
        rsp_data     <= alu_out;
        rsp_overflow <= alu_overflow;
        rsp_gr       <= alu_gr;
        rsp_le       <= alu_le;
        rsp_eq       <= alu_eq;
      end
    end
  end

  // Steer the response pulse to the port that issued the operation.
  always_comb begin
    rsp0_valid = s2_valid && !s2_tag;
    rsp1_valid = s2_valid &&  s2_tag;
  end

  // Completed-operation counters, advanced as stage 2 retires each result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops0_count <= '0;
      ops1_count <= '0;
    end else begin
      if (rsp0_valid) ops0_count <= ops0_count + CNT_ONE;
      if (rsp1_valid) ops1_count <= ops1_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: scenario tasks with inline checks plus a
// response scoreboard fed from accepted requests.

`ifndef ADDMODULE
`define ADDMODULE 4'd0
`endif
`ifndef SUBMODULE
`define SUBMODULE 4'd1
`endif
`ifndef MULMODULE
`define MULMODULE 4'd2
`endif
`ifndef NOTMODULE
`define NOTMODULE 4'd3
`endif

module tb_alu_arbiter;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req0_lock;
  logic [10:0]   req0_a, req0_b;
  logic [3:0]    req0_funct;
  logic          req1_valid, req1_ready, req1_lock;
  logic [10:0]   req1_a, req1_b;
  logic [3:0]    req1_funct;
  logic          rsp0_valid, rsp1_valid;
  logic [10:0]   rsp_data;
  logic          rsp_overflow, rsp_gr, rsp_le, rsp_eq;
  logic [CW-1:0] ops0_count, ops1_count;

  int cmp_count;
  int err_count;

  // {port, data[10:0], overflow, gr, le, eq}
  logic [15:0] exp_q[$];

  alu_arbiter #(.MAX_LOCK(4), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_lock    (req0_lock),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_funct   (req0_funct),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_lock    (req1_lock),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_funct   (req1_funct),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .rsp_gr       (rsp_gr),
    .rsp_le       (rsp_le),
    .rsp_eq       (rsp_eq),
    .ops0_count   (ops0_count),
    .ops1_count   (ops1_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic, then range check for overflow.
  function automatic logic [15:0] model(input logic port, input int a, input int b,
                                        input logic [3:0] f);
    int   r;
    logic ov;
    r  = 0;
    ov = 1'b0;
    case (f)
      `ADDMODULE: r = a + b;
      `SUBMODULE: r = a - b;
      `MULMODULE: r = a * b;
      `NOTMODULE: r = ~a;
      default:    r = 0;
    endcase
    if (f != `NOTMODULE) ov = (r > 1023) || (r < -1024);
    return {port, r[10:0], ov, (a > b), (a < b), (a == b)};
  endfunction

  // Scoreboard: push on accept, pop and compare on response, away from the edge.
  always @(negedge clk) begin
    logic [15:0] got;
    logic [15:0] exp;
    if (!reset) begin
      if (rsp0_valid || rsp1_valid) begin
        cmp_count++;
        got = {rsp1_valid, rsp_data, rsp_overflow, rsp_gr, rsp_le, rsp_eq};
        if (rsp0_valid && rsp1_valid) begin
          err_count++;
          $display("FAIL rsp_both: rsp0_valid=%b rsp1_valid=%b, required one-hot", rsp0_valid, rsp1_valid);
        end else if (exp_q.size() == 0) begin
          err_count++;
          $display("FAIL rsp_unexpected: got %h, required no response", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            err_count++;
            $display("FAIL rsp_match: got %h, required %h", got, exp);
          end
        end
      end
      if (req0_valid && req0_ready)
        exp_q.push_back(model(1'b0, $signed(req0_a), $signed(req0_b), req0_funct));
      if (req1_valid && req1_ready)
        exp_q.push_back(model(1'b1, $signed(req1_a), $signed(req1_b), req1_funct));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic l, input int a, input int b, input logic [3:0] f);
    req0_valid = v; req0_lock = l; req0_a = a[10:0]; req0_b = b[10:0]; req0_funct = f;
  endtask

  task automatic drive1(input logic v, input logic l, input int a, input int b, input logic [3:0] f);
    req1_valid = v; req1_lock = l; req1_a = a[10:0]; req1_b = b[10:0]; req1_funct = f;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 0, 0, `ADDMODULE);
    drive1(1'b0, 1'b0, 0, 0, `ADDMODULE);
  endtask

  task automatic do_reset();
    step();
    idle();
    reset = 1'b1;
    #10;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    drive0(1'b1, 1'b0, 1, 2, `ADDMODULE);
    drive1(1'b1, 1'b0, 3, 4, `SUBMODULE);
    #2;
    cmp_count++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      err_count++;
      $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
    end
    cmp_count++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      err_count++;
      $display("FAIL reset_rsp_valid: got %b, required 00", {rsp0_valid, rsp1_valid});
    end
    cmp_count++;
    if ({rsp_data, rsp_overflow, rsp_gr, rsp_le, rsp_eq} !== 15'd0) begin
      err_count++;
      $display("FAIL reset_rsp_data: got %h, required 0", {rsp_data, rsp_overflow, rsp_gr, rsp_le, rsp_eq});
    end
    cmp_count++;
    if ({ops0_count, ops1_count} !== '0) begin
      err_count++;
      $display("FAIL reset_counts: got %0d/%0d, required 0/0", ops0_count, ops1_count);
    end
    step();
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    drive0(1'b1, 1'b0, 200, 4, `ADDMODULE);
    #1;
    cmp_count++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      err_count++;
      $display("FAIL single_ready: got %b, required 10", {req0_ready, req1_ready});
    end
    step();
    idle();
    step();
    cmp_count++;
    if ({rsp0_valid, rsp1_valid, rsp_data, rsp_overflow, rsp_gr, rsp_le, rsp_eq} !==
        {1'b1, 1'b0, 11'd204, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      err_count++;
      $display("FAIL single_rsp: got v=%b%b data=%0d flags=%b%b%b%b, required v=10 data=204 flags=0100",
               rsp0_valid, rsp1_valid, rsp_data, rsp_overflow, rsp_gr, rsp_le, rsp_eq);
    end
    step();
    cmp_count++;
    if ({rsp0_valid, ops0_count, ops1_count} !== {1'b0, 4'd1, 4'd0}) begin
      err_count++;
      $display("FAIL single_count: got rsp0=%b ops=%0d/%0d, required rsp0=0 ops=1/0",
               rsp0_valid, ops0_count, ops1_count);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    drive0(1'b1, 1'b0, 500, 550, `MULMODULE);
    drive1(1'b1, 1'b0, 20, -3, `SUBMODULE);
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp_count++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        err_count++;
        $display("FAIL alternate_grant[%0d]: got %b, required %b", i, {req0_ready, req1_ready},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
    end
    idle();
    repeat (3) step();
    cmp_count++;
    if ({ops0_count, ops1_count} !== {4'd2, 4'd2}) begin
      err_count++;
      $display("FAIL alternate_counts: got %0d/%0d, required 2/2", ops0_count, ops1_count);
    end
  endtask

  task automatic test_lock();
    int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    drive0(1'b1, 1'b1, 7, 3, `ADDMODULE);
    drive1(1'b1, 1'b0, 9, 9, `NOTMODULE);
    for (int i = 0; i < 10; i++) begin
      req0_a = 11'($urandom_range(0, 2047));
      #1;
      cmp_count++;
      if ({req0_ready, req1_ready} !== ((pat[i] == 0) ? 2'b10 : 2'b01)) begin
        err_count++;
        $display("FAIL lock_grant[%0d]: got %b, required port %0d", i, {req0_ready, req1_ready}, pat[i]);
      end
      step();
    end
    idle();
    repeat (3) step();
    cmp_count++;
    if ({ops0_count, ops1_count} !== {4'd8, 4'd2}) begin
      err_count++;
      $display("FAIL lock_counts: got %0d/%0d, required 8/2", ops0_count, ops1_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive0(1'b1, 1'b0, 600, -450, `ADDMODULE);
    step();
    drive0(1'b1, 1'b0, 600, -450, `SUBMODULE);
    step();
    idle();
    cmp_count++;
    if ({rsp0_valid, rsp_data, rsp_overflow} !== {1'b1, 11'd150, 1'b0}) begin
      err_count++;
      $display("FAIL b2b_first: got v=%b data=%0d ov=%b, required v=1 data=150 ov=0",
               rsp0_valid, rsp_data, rsp_overflow);
    end
    step();
    cmp_count++;
    if ({rsp0_valid, rsp_overflow} !== 2'b11) begin
      err_count++;
      $display("FAIL b2b_second: got v=%b ov=%b, required v=1 ov=1", rsp0_valid, rsp_overflow);
    end
    step();
    cmp_count++;
    if ({rsp0_valid, ops0_count} !== {1'b0, 4'd2}) begin
      err_count++;
      $display("FAIL b2b_done: got v=%b ops0=%0d, required v=0 ops0=2", rsp0_valid, ops0_count);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    drive0(1'b1, 1'b0, 100, 5, `ADDMODULE);
    drive1(1'b1, 1'b0, 30, 6, `SUBMODULE);
    repeat (4) step();
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    cmp_count++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ops0_count, ops1_count} !== '0) begin
      err_count++;
      $display("FAIL inflight_reset: got ready=%b%b rsp=%b%b ops=%0d/%0d, required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, ops0_count, ops1_count);
    end
    step();
    step();
    reset = 1'b0;
    #1;
    cmp_count++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      err_count++;
      $display("FAIL inflight_regrant: got %b, required 10", {req0_ready, req1_ready});
    end
    step();
    idle();
    repeat (3) step();
    cmp_count++;
    if ({ops0_count, ops1_count} !== {4'd1, 4'd0}) begin
      err_count++;
      $display("FAIL inflight_counts: got %0d/%0d, required 1/0", ops0_count, ops1_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive1(1'b1, 1'b0, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
             4'($urandom_range(0, 3)));
      step();
    end
    idle();
    repeat (3) step();
    cmp_count++;
    if ({ops0_count, ops1_count} !== {4'd0, 4'd1}) begin
      err_count++;
      $display("FAIL wrap_counts: got %0d/%0d, required 0/1", ops0_count, ops1_count);
    end
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_back_to_back();
    test_reset_inflight();
    test_wrap();
    repeat (3) step();
    cmp_count++;
    if (exp_q.size() != 0) begin
      err_count++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 11-bit `alu` instance between two requesters, such as two MCU cores or a core and a test sequencer. It arbitrates round-robin, with an optional bounded lock for back-to-back sequences. It pipelines each granted operation through a registered operand stage and a registered result stage, then returns the result and flags to the originating port. The block sits between requester logic and the shared ALU and instantiates the `alu` internally.

## Interface
- `MAX_LOCK`, default 4: maximum consecutive grants one port may hold via lock; range 1–15.
- `CNT_WIDTH`, default 16: width of the per-port completed-operation counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0_valid`, `req1_valid` in 1: request pending.
- `req0_ready`, `req1_ready` out 1: grant; the request is accepted on an edge where valid and ready are both high.
- `req0_lock`, `req1_lock` in 1: ask to keep priority for the next cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 11: two's-complement operands (`in0`, `in1`).
- `req0_funct`, `req1_funct` in 4: ALU function code (`ADDMODULE`, `SUBMODULE`, `MULMODULE`, `NOTMODULE` macros).
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle response pulse to the originating port.
- `rsp_data` out 11: registered ALU `out`.
- `rsp_overflow`, `rsp_gr`, `rsp_le`, `rsp_eq` out 1: registered ALU flags.
- `ops0_count`, `ops1_count` out `CNT_WIDTH`: completed responses per port; wrap modulo 2^`CNT_WIDTH`.

## Operation
- **Grant (combinational from registered state)**
  - Only one valid: that port gets ready.
  - Both valid: the port selected by `prio` gets ready.
  - Neither valid: both ready low.
  - Ready never depends on the other port's `ready`.
- **Priority pointer `prio`**
  - After reset, `prio` = 0 (port 0 favoured).
  - On each accept from port p without lock, `prio` moves to the other port.
- **Lock**
  - If accepted port p has `reqp_lock`=1 and `lock_cnt` < `MAX_LOCK`−1, then `prio` stays p and `lock_cnt` increments.
  - Otherwise `lock_cnt` clears and `prio` moves to the other port.
  - `lock_cnt` clears on any cycle with no accept.
  - A lock with the other port idle has no effect beyond the counter.
- **Stage 1 (operand register)**
  - On accept, capture a, b, funct and tag = p; set `s1_valid`.
  - Otherwise `s1_valid` clears.
  - The ALU is driven only from stage-1 registers.
- **Stage 2 (result register)**
  - Each edge, capture ALU out and flags plus tag when `s1_valid`; `s2_valid` = `s1_valid`.
  - `rspp_valid` = `s2_valid` && tag==p.
  - `rsp_data` and flags hold their last value when `s2_valid`=0.
- **Counters:** `opsp_count` increments on the edge after each `rspp_valid` cycle, i.e. when stage 2 retires a result for port p.
- **No backpressure:** the pipeline always advances, so accepted operations are never stalled or dropped except by reset.
- **Arithmetic:** the ALU is used as-is. 11-bit results wrap; overflow and comparison flags are the ALU's, unmodified. `NOTMODULE` result is returned unmodified.

## Timing
- Accept on edge k. Stage 1 is valid during cycle k→k+1. Result is registered on edge k+1. `rspp_valid` is high for exactly the cycle between edges k+1 and k+2.
- Latency is 2 cycles; throughput is 1 operation per cycle across both ports.
- Responses return in acceptance order, one per cycle maximum.
- **Reset (asynchronous, any time)**
  - Clears `s1_valid`, `s2_valid`, `prio`=0, `lock_cnt`=0 and both counters.
  - `rsp_data`=0 and all `rsp_*` flags = 0.
  - `req*_ready` = 0 while reset is high.
  - In-flight operations are discarded and produce no response.
- **Simultaneous events**
  - An accept and a response in the same cycle are independent.
  - A port may have a response pulse and a new accept in the same cycle.
- **Counter wrap:** at all ones, the counter goes to 0.

## Test plan
- Port 0 only, a=200, b=4, ADD → `req0_ready`=1 at once; `rsp0_valid` 2 cycles later; `rsp_data`=204, `rsp_overflow`=0, `rsp_gr`=1, `rsp_le`=0, `rsp_eq`=0; `rsp1_valid` never pulses; `ops0_count`=1.
- Both ports valid from reset: port 0 MUL 500×550, port 1 SUB 20−(−3), held 4 cycles → grants alternate 0,1,0,1. Responses alternate: `rsp_overflow`=1 for port 0; `rsp_data`=23, `rsp_overflow`=0 for port 1. Final counts 2 and 2.
- `MAX_LOCK`=4, port 0 valid+lock for 10 cycles, port 1 valid throughout → grant pattern 0,0,0,0,1,0,0,0,0,1; no port waits more than 4 cycles.
- Port 0 issues ADD 600+(−450) then SUB 600−(−450) on consecutive cycles → back-to-back `rsp0_valid` pulses. First: `rsp_data`=150, `rsp_overflow`=0. Second: `rsp_overflow`=1. Throughput is 1 per cycle.
- Reset asserted asynchronously mid-cycle with two operations in flight → ready, `rsp*_valid` and counters drop to 0 immediately; no response after release; first post-reset request is granted to port 0 when both are valid.
- `CNT_WIDTH`=4, 17 port-1 operations → `ops1_count` reads 1 after wrap.
